// File: rtl/fwpayload_wb_arb_pkg.sv
// Shared types for the two-initiator payload Wishbone arbiter.
// Imported by the round-robin picker and the arbiter top.
package fwpayload_wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  typedef logic owner_t;

  localparam int NUM_INITIATORS = 2;

endpackage

// File: rtl/fwpayload_rr_arb2.sv
// Two-way round-robin pick: on a tie the initiator that
// did not own the bus last wins.
module fwpayload_rr_arb2
  import fwpayload_wb_arb_pkg::*;
(
  input  logic [NUM_INITIATORS-1:0] req,
  input  owner_t                    last_owner,
  output logic                      valid,
  output owner_t                    winner
);

  always_comb begin
    valid  = |req;
    winner = req[1];
    if (&req) winner = ~last_owner;
  end

endmodule

// File: rtl/fwpayload_wb_arbiter.sv
// Shares the payload Wishbone target between the host bus (m0)
// and the LA debug initiator (m1), with per-transfer timeout.
module fwpayload_wb_arbiter
  import fwpayload_wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH-1:0]   m0_dat_w,
  output logic [DATA_WIDTH-1:0]   m0_dat_r,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH-1:0]   m1_dat_w,
  output logic [DATA_WIDTH-1:0]   m1_dat_r,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic [ADDR_WIDTH-1:0]   t_adr,
  output logic [DATA_WIDTH-1:0]   t_dat_w,
  input  logic [DATA_WIDTH-1:0]   t_dat_r,
  output logic                    t_cyc,
  output logic                    t_stb,
  output logic                    t_we,
  output logic [DATA_WIDTH/8-1:0] t_sel,
  input  logic                    t_ack,
  output logic [1:0]              grant,
  output logic [CNT_WIDTH-1:0]    timeout_count
);

  localparam logic [CNT_WIDTH-1:0] LIMIT =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t           state_q, state_d;
  owner_t               owner_q, last_q, winner;
  logic                 valid;
  logic [CNT_WIDTH-1:0] to_cnt_q;
  logic [1:0]           req;
  logic                 granted, own_cyc, live;
  logic                 at_limit, xfer_ack, xfer_err, done;

  assign req      = {m1_cyc & m1_stb, m0_cyc & m0_stb};
  assign granted  = (state_q == ARB_GRANT);
  assign own_cyc  = owner_q ? m1_cyc : m0_cyc;
  assign live     = granted & own_cyc;
  assign at_limit = (to_cnt_q == LIMIT);
  assign xfer_ack = live & t_ack;
  assign xfer_err = live & ~t_ack & at_limit;
  // Abort, ack and timeout all end the grant.
  assign done     = granted & (~own_cyc | t_ack | at_limit);

  fwpayload_rr_arb2 u_pick (
    .req        (req),
    .last_owner (last_q),
    .valid      (valid),
    .winner     (winner)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      to_cnt_q      <= '0;
      timeout_count <= '0;
    end else begin
      if (!granted && valid) owner_q <= winner;
      if (done) last_q <= owner_q;
      if (!granted)    to_cnt_q <= '0;
      else if (!t_ack) to_cnt_q <= to_cnt_q + 1'b1;
      if (xfer_err && !(&timeout_count))
        timeout_count <= timeout_count + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (valid) state_d = ARB_GRANT;
      ARB_GRANT: if (done)  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    t_adr    = '0;
    t_dat_w  = '0;
    t_cyc    = 1'b0;
    t_stb    = 1'b0;
    t_we     = 1'b0;
    t_sel    = '0;
    grant    = 2'b00;
    m0_dat_r = '0;
    m1_dat_r = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_err   = 1'b0;
    if (granted) begin
      t_cyc = own_cyc;
      if (owner_q) begin
        t_adr    = m1_adr;
        t_dat_w  = m1_dat_w;
        t_stb    = m1_stb & m1_cyc;
        t_we     = m1_we;
        t_sel    = m1_sel;
        grant    = 2'b10;
        m1_dat_r = t_dat_r;
        m1_ack   = xfer_ack;
        m1_err   = xfer_err;
      end else begin
        t_adr    = m0_adr;
        t_dat_w  = m0_dat_w;
        t_stb    = m0_stb & m0_cyc;
        t_we     = m0_we;
        t_sel    = m0_sel;
        grant    = 2'b01;
        m0_dat_r = t_dat_r;
        m0_ack   = xfer_ack;
        m0_err   = xfer_err;
      end
    end
  end

endmodule

// File: tb/tb_fwpayload_wb_arbiter.sv
// Directed bench for fwpayload_wb_arbiter.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_fwpayload_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_adr = '0, m0_dat_w = '0, m0_dat_r;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m1_adr = '0, m1_dat_w = '0, m1_dat_r;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = '0;
  logic        m1_ack, m1_err;
  logic [31:0] t_adr, t_dat_w, t_dat_r = '0;
  logic        t_cyc, t_stb, t_we;
  logic [3:0]  t_sel;
  logic        t_ack = 1'b0;
  logic [1:0]  grant;
  logic [15:0] timeout_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fwpayload_wb_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
    .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
    .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we),
    .t_sel(t_sel), .t_ack(t_ack),
    .grant(grant), .timeout_count(timeout_count)
  );

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic m0_req(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat);
    m0_cyc = 1; m0_stb = 1; m0_we = we;
    m0_adr = adr; m0_dat_w = dat; m0_sel = 4'hf;
  endtask

  task automatic m1_req(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat);
    m1_cyc = 1; m1_stb = 1; m1_we = we;
    m1_adr = adr; m1_dat_w = dat; m1_sel = 4'hf;
  endtask

  task automatic clear_all();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0;
    t_ack = 0; t_dat_r = '0;
  endtask

  task automatic test_reset();
    edge1(); edge1();
    neg();
    checks++;
    if ({grant, t_cyc, t_stb, m0_ack, m1_ack, m0_err, m1_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs: got grant=%b cyc=%b stb=%b acks=%b%b errs=%b%b want all 0",
               grant, t_cyc, t_stb, m0_ack, m1_ack, m0_err, m1_err);
    end
    checks++;
    if (timeout_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_tocnt: got %0d want 0", timeout_count);
    end
    edge1(); reset = 0;
    neg();
  endtask

  task automatic test_write();
    edge1(); m0_req(1'b1, 32'h3000_0004, 32'hDEAD_BEEF);
    neg();
    checks++;
    if (grant !== 2'b00 || t_cyc !== 1'b0) begin
      errors++;
      $display("FAIL wr_pre_grant: got grant=%b cyc=%b want 00/0", grant, t_cyc);
    end
    edge1(); neg();
    checks++;
    if (grant !== 2'b01 || t_cyc !== 1'b1 || t_stb !== 1'b1 || t_we !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant: got grant=%b cyc=%b stb=%b we=%b want 01/1/1/1",
               grant, t_cyc, t_stb, t_we);
    end
    checks++;
    if (t_adr !== 32'h3000_0004 || t_dat_w !== 32'hDEAD_BEEF || t_sel !== 4'hf) begin
      errors++;
      $display("FAIL wr_fwd: got adr=%h dat=%h sel=%h want 30000004/deadbeef/f",
               t_adr, t_dat_w, t_sel);
    end
    checks++;
    if (m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_early_ack: got %b want 0", m0_ack);
    end
    edge1(); t_ack = 1;
    neg();
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack: got m0_ack=%b m0_err=%b m1_ack=%b want 1/0/0",
               m0_ack, m0_err, m1_ack);
    end
    edge1(); clear_all();
    neg();
    checks++;
    if (grant !== 2'b00 || m0_ack !== 1'b0 || t_cyc !== 1'b0) begin
      errors++;
      $display("FAIL wr_release: got grant=%b ack=%b cyc=%b want 00/0/0",
               grant, m0_ack, t_cyc);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [8] = '{2'b00, 2'b01, 2'b00, 2'b10,
                              2'b00, 2'b01, 2'b00, 2'b10};
    edge1(); reset = 1;
    m0_req(1'b1, 32'h3000_0100, 32'h1);
    m1_req(1'b1, 32'h3000_0200, 32'h2);
    t_ack = 1;
    edge1(); reset = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) edge1();
      neg();
      checks++;
      if (grant !== exp_g[i]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, exp_g[i]);
      end
      checks++;
      if (m0_ack !== exp_g[i][0] || m1_ack !== exp_g[i][1]) begin
        errors++;
        $display("FAIL rr_ack[%0d]: got m0=%b m1=%b want %b/%b",
                 i, m0_ack, m1_ack, exp_g[i][0], exp_g[i][1]);
      end
    end
    edge1(); clear_all();
    neg();
  endtask

  task automatic test_read();
    edge1(); m1_req(1'b0, 32'h3000_0010, 32'h0);
    neg();
    edge1(); neg();
    checks++;
    if (grant !== 2'b10 || t_adr !== 32'h3000_0010 || t_we !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: got grant=%b adr=%h we=%b want 10/30000010/0",
               grant, t_adr, t_we);
    end
    edge1(); t_ack = 1; t_dat_r = 32'h1234_5678;
    neg();
    checks++;
    if (m1_dat_r !== 32'h1234_5678 || m1_ack !== 1'b1) begin
      errors++;
      $display("FAIL rd_data: got dat=%h ack=%b want 12345678/1", m1_dat_r, m1_ack);
    end
    checks++;
    if (m0_dat_r !== 32'h0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_other: got m0_dat=%h m0_ack=%b want 0/0", m0_dat_r, m0_ack);
    end
    edge1(); clear_all();
    neg();
  endtask

  task automatic test_timeout();
    for (int run = 0; run < 2; run++) begin
      edge1(); m0_req(1'b1, 32'h3000_0020, 32'h55);
      neg();
      for (int k = 1; k <= 8; k++) begin
        edge1();
        if (run == 1 && k == 8) t_ack = 1;
        neg();
        checks++;
        if (m0_err !== (run == 0 && k == 8) ||
            m0_ack !== (run == 1 && k == 8) || t_cyc !== 1'b1) begin
          errors++;
          $display("FAIL to_cycle[run%0d,k%0d]: got err=%b ack=%b cyc=%b want %b/%b/1",
                   run, k, m0_err, m0_ack, t_cyc,
                   (run == 0 && k == 8), (run == 1 && k == 8));
        end
      end
      edge1(); clear_all();
      neg();
      checks++;
      if (t_cyc !== 1'b0 || grant !== 2'b00 || timeout_count !== 16'd1) begin
        errors++;
        $display("FAIL to_after[run%0d]: got cyc=%b grant=%b count=%0d want 0/00/1",
                 run, t_cyc, grant, timeout_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    edge1(); m1_req(1'b1, 32'h3000_0030, 32'h77);
    neg();
    edge1(); neg();
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL rm_grant_m1: got %b want 10", grant);
    end
    edge1(); reset = 1;
    edge1(); m0_req(1'b1, 32'h3000_0040, 32'h88);
    neg();
    checks++;
    if ({grant, t_cyc, t_stb, t_we, m1_ack, m1_err} !== 7'h00 ||
        t_adr !== 32'h0 || t_dat_w !== 32'h0 || timeout_count !== 16'd0) begin
      errors++;
      $display("FAIL rm_outs: got grant=%b cyc=%b adr=%h ack=%b err=%b count=%0d want all 0",
               grant, t_cyc, t_adr, m1_ack, m1_err, timeout_count);
    end
    edge1(); reset = 0;
    neg();
    edge1(); neg();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL rm_first_tie: got %b want 01", grant);
    end
    edge1(); t_ack = 1;
    neg();
    edge1(); clear_all();
    neg();
  endtask

  task automatic test_abort();
    edge1(); m0_req(1'b1, 32'h3000_0050, 32'h99);
    neg();
    edge1(); neg();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL ab_grant: got %b want 01", grant);
    end
    edge1(); m1_req(1'b1, 32'h3000_0060, 32'haa);
    neg();
    edge1(); m0_cyc = 0; m0_stb = 0;
    neg();
    checks++;
    if (t_cyc !== 1'b0 || t_stb !== 1'b0 ||
        m0_ack !== 1'b0 || m0_err !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL ab_drop: got cyc=%b stb=%b ack=%b err=%b m1_ack=%b want all 0",
               t_cyc, t_stb, m0_ack, m0_err, m1_ack);
    end
    edge1(); neg();
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL ab_dead: got %b want 00", grant);
    end
    edge1(); neg();
    checks++;
    if (grant !== 2'b10 || t_cyc !== 1'b1 || t_adr !== 32'h3000_0060) begin
      errors++;
      $display("FAIL ab_next: got grant=%b cyc=%b adr=%h want 10/1/30000060",
               grant, t_cyc, t_adr);
    end
    edge1(); t_ack = 1;
    neg();
    edge1(); clear_all();
    neg();
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_read();
    test_timeout();
    test_reset_mid();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
